// File: rtl/vk_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vk_arbiter
// Brief    : Single-port VGA/CPU arbiter for the shared VGA/keyboard memory,
//            VGA-priority with a starvation bound and tagged read returns.
// Revision : 1.0
// ============================================================================
module vk_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        sys_clk,
    input  logic        rst,

    input  logic        vga_req,
    input  logic [31:0] vga_addr,
    output logic        vga_ack,
    output logic        vga_rvalid,
    output logic [31:0] vga_rdata,

    input  logic        cpu_req,
    input  logic        cpu_wren,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,

    output logic [31:0] vk_addr,
    output logic        vk_wren,
    output logic [31:0] vk_wdata,
    input  logic [31:0] vk_rdata
);

    // Out-of-range settings are clamped into the 4-bit counter range 1..15.
    localparam logic [3:0] c_STARVE_LIMIT =
        (STARVE_MAX > 32'd15) ? 4'd15 :
        (STARVE_MAX < 32'd1)  ? 4'd1  : 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    logic [3:0]  starve_q;
    logic [3:0]  starve_d;
    logic [31:0] vk_addr_q;
    logic [31:0] vk_addr_d;
    logic        vk_wren_q;
    logic        vk_wren_d;
    logic [31:0] vk_wdata_q;
    logic [31:0] vk_wdata_d;
    tag_t        tag1_q;
    tag_t        tag1_d;
    tag_t        tag2_q;

    logic        w_starved;
    logic        w_grant_vga;
    logic        w_grant_cpu;

    // Grant: VGA wins unless the CPU has waited through STARVE_MAX VGA grants.
    always_comb begin
        w_starved   = (starve_q >= c_STARVE_LIMIT);
        w_grant_vga = 1'b0;
        w_grant_cpu = 1'b0;
        if (!rst) begin
            if (vga_req && !(cpu_req && w_starved)) begin
                w_grant_vga = 1'b1;
            end else if (cpu_req) begin
                w_grant_cpu = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!cpu_req || w_grant_cpu) begin
            starve_d = 4'd0;
        end else if (w_grant_vga && (starve_q < c_STARVE_LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        vk_addr_d  = vk_addr_q;
        vk_wren_d  = 1'b0;
        vk_wdata_d = vk_wdata_q;
        tag1_d     = TAG_NONE;
        if (w_grant_vga) begin
            vk_addr_d = vga_addr;
            tag1_d    = TAG_VGA;
        end else if (w_grant_cpu) begin
            vk_addr_d  = cpu_addr;
            vk_wren_d  = cpu_wren;
            vk_wdata_d = cpu_wdata;
            tag1_d     = cpu_wren ? TAG_NONE : TAG_CPU;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            starve_q   <= 4'd0;
            vk_addr_q  <= 32'd0;
            vk_wren_q  <= 1'b0;
            vk_wdata_q <= 32'd0;
            tag1_q     <= TAG_NONE;
            tag2_q     <= TAG_NONE;
        end else begin
            starve_q   <= starve_d;
            vk_addr_q  <= vk_addr_d;
            vk_wren_q  <= vk_wren_d;
            vk_wdata_q <= vk_wdata_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
        end
    end

    assign vga_ack    = w_grant_vga;
    assign cpu_ack    = w_grant_cpu;

    assign vk_addr    = vk_addr_q;
    assign vk_wren    = vk_wren_q;
    assign vk_wdata   = vk_wdata_q;

    // Memory data lands two cycles after the ack, aligned with the stage-2 tag.
    assign vga_rvalid = (tag2_q == TAG_VGA);
    assign cpu_rvalid = (tag2_q == TAG_CPU);
    assign vga_rdata  = vk_rdata;
    assign cpu_rdata  = vk_rdata;

endmodule
`default_nettype wire
